// File: rtl/divide16_seq_if.sv
// Request/result bundle for the radix-16 divider sequencer: start with operands in,
// busy/done/quotient/remainder/error out.
interface divide16_seq_if #(
  parameter int unsigned QW = 8
);
  logic          start;
  logic [7:0]    a_in;
  logic [7:0]    b_in;
  logic          busy;
  logic          done;
  logic [QW-1:0] quotient;
  logic [7:0]    rem;
  logic          err;

  modport master (
    output start, a_in, b_in,
    input  busy, done, quotient, rem, err
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, quotient, rem, err
  );
endinterface

// File: rtl/divide16_seq.sv
// Sequencer for the radix-16 SRT divider datapath (two radix-4 digits per clock).
// Optional operand check is enabled by defining DIVIDE16_OPCHK_EN.
module divide16_seq #(
  parameter int unsigned ITERS = 2,
  parameter int unsigned RW    = 11
) (
  input  logic          clk,
  input  logic          reset_b,
  divide16_seq_if.slave req,
  output logic [7:0]    op1,
  output logic [7:0]    op2,
  output logic          state0,
  input  logic [3:0]    qj,
  input  logic [3:0]    qjn,
  input  logic [RW-1:0] sum2,
  input  logic [RW-1:0] carry2
);
  localparam int unsigned QW = 4 * ITERS;
  localparam int unsigned AW = QW + 2;
  localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  // Residual carries the remainder scaled by 2^SH relative to the 8-bit divisor.
  localparam int unsigned SH = RW - 9;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [7:0]           op1_q, op1_d, op2_q, op2_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [RW-1:0]        r_q, r_d;
  logic [QW-1:0]        quot_q, quot_d;
  logic [7:0]           rem_q, rem_d;

  logic signed [2:0]    d1, d2;
  logic signed [AW-1:0] d1e, d2e, acc_iter, acc_fix;
  logic [RW-1:0]        r_fix;

  function automatic logic signed [2:0] dig(input logic [3:0] c);
    case (c)
      4'b0001: return 3'sd2;
      4'b0010: return 3'sd1;
      4'b0100: return -3'sd1;
      4'b1000: return -3'sd2;
      default: return 3'sd0;
    endcase
  endfunction

  always_comb begin
    d1       = dig(qj);
    d2       = dig(qjn);
    d1e      = {{(AW-3){d1[2]}}, d1};
    d2e      = {{(AW-3){d2[2]}}, d2};
    acc_iter = (acc_q <<< 4) + (d1e <<< 2) + d2e;
    acc_fix  = acc_q;
    r_fix    = r_q;
    if (r_q[RW-1]) begin
      acc_fix = acc_q - AW'(1);
      r_fix   = r_q + (RW'(op2_q) << SH);
    end
  end

`ifdef DIVIDE16_OPCHK_EN
  logic err_q, err_d;
  logic bad_ops;
  assign bad_ops = ~req.b_in[7] | (req.a_in >= req.b_in);
  assign req.err = err_q;
`else
  assign req.err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIVIDE16_OPCHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req.start) begin
          op1_d = req.a_in;
          op2_d = req.b_in;
`ifdef DIVIDE16_OPCHK_EN
          if (bad_ops) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
          end else begin
            state_d = S_LOAD;
            err_d   = 1'b0;
          end
`else
          state_d = S_LOAD;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        acc_d = acc_iter;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          r_d     = sum2 + carry2;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        acc_d   = acc_fix;
        r_d     = r_fix;
        quot_d  = acc_fix[QW-1:0];
        rem_d   = r_fix[SH +: 8];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIVIDE16_OPCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIVIDE16_OPCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign op1          = op1_q;
  assign op2          = op2_q;
  assign state0       = (state_q == S_LOAD);
  assign req.busy     = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
  assign req.done     = (state_q == S_DONE);
  assign req.quotient = quot_q;
  assign req.rem      = rem_q;
endmodule

// File: tb/tb_divide16_seq.sv
// Directed bench for divide16_seq; the bench plays the datapath by supplying digits and residuals.
module tb_divide16_seq;
  localparam int unsigned ITERS = 2;
  localparam int unsigned RW    = 11;
  localparam int unsigned QW    = 8;

  logic          clk = 1'b0;
  logic          reset_b;
  logic [7:0]    op1, op2;
  logic          state0;
  logic [3:0]    qj, qjn;
  logic [RW-1:0] sum2, carry2;
  int            total = 0;
  int            bad = 0;

  divide16_seq_if #(.QW(QW)) bus ();

  divide16_seq #(.ITERS(ITERS), .RW(RW)) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .req    (bus.slave),
    .op1    (op1),
    .op2    (op2),
    .state0 (state0),
    .qj     (qj),
    .qjn    (qjn),
    .sum2   (sum2),
    .carry2 (carry2)
  );

  always #5 clk = ~clk;

  // Issues one start and plays the datapath; returns in the done cycle (or after the bound).
  task automatic drive_div(input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] q1, input logic [3:0] n1,
                           input logic [3:0] q2, input logic [3:0] n2,
                           input logic [10:0] s, input logic [10:0] c, input bit hold,
                           output int lat, output int s0cnt, output bit s0_first,
                           output bit ops_ok);
    bus.a_in = a;
    bus.b_in = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    s0cnt = 0;
    s0_first = state0;
    ops_ok = 1'b1;
    if (hold) begin
      bus.a_in = 8'h33;
      bus.b_in = 8'h44;
    end else begin
      bus.start = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      if (state0) s0cnt++;
      if (op1 !== a || op2 !== b) ops_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (i >= 3) bus.start = 1'b0;
      qj     = (i == 1) ? q1 : (i == 2) ? q2 : 4'b0001;
      qjn    = (i == 1) ? n1 : (i == 2) ? n2 : 4'b0010;
      sum2   = (i == 2) ? s : 11'h3A5;
      carry2 = (i == 2) ? c : 11'h0F0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    qj = '0;
    qjn = '0;
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0;
    qj = '0; qjn = '0; sum2 = '0; carry2 = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({op1, op2, state0, bus.busy, bus.done, bus.err} !== 20'h0) begin
      bad++; $display("FAIL reset_ctrl: got %h want 0", {op1, op2, state0, bus.busy, bus.done, bus.err});
    end
    total++;
    if ({bus.quotient, bus.rem} !== 16'h0) begin
      bad++; $display("FAIL reset_result: got %h want 0", {bus.quotient, bus.rem});
    end
    reset_b = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic;
    int lat, s0; bit s0f, ok;
    drive_div(8'h40, 8'h80, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 11'h155, 11'h6AB, 1'b0, lat, s0, s0f, ok);
    total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
    total++; if (s0 !== 1) begin bad++; $display("FAIL basic_state0_cycles: got %0d want 1", s0); end
    total++; if (bus.quotient !== 8'h80) begin bad++; $display("FAIL basic_quot: got %h want 80", bus.quotient); end
    total++; if (bus.rem !== 8'h00) begin bad++; $display("FAIL basic_rem: got %h want 00", bus.rem); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done: got %b want 0", bus.busy); end
    total++; if (!ok) begin bad++; $display("FAIL basic_ops: got 0 want 1"); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_correction;
    int lat, s0; bit s0f, ok;
    // Direct digits 6,10 with residual +0x200.
    drive_div(8'h50, 8'hC0, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 11'h100, 11'h100, 1'b0, lat, s0, s0f, ok);
    total++; if (bus.quotient !== 8'h6A) begin bad++; $display("FAIL direct_quot: got %h want 6a", bus.quotient); end
    total++; if (bus.rem !== 8'h80) begin bad++; $display("FAIL direct_rem: got %h want 80", bus.rem); end
    @(posedge clk); #1;
    // Digits 7,-5 give 107 with residual -0x100; correction must yield 106 / 0x80.
    drive_div(8'h50, 8'hC0, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 11'h6F0, 11'h010, 1'b0, lat, s0, s0f, ok);
    total++; if (lat !== 4) begin bad++; $display("FAIL corr_latency: got %0d want 4", lat); end
    total++; if (bus.quotient !== 8'h6A) begin bad++; $display("FAIL corr_quot: got %h want 6a", bus.quotient); end
    total++; if (bus.rem !== 8'h80) begin bad++; $display("FAIL corr_rem: got %h want 80", bus.rem); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.quotient !== 8'h6A || bus.rem !== 8'h80 || bus.done !== 1'b0) begin
      bad++; $display("FAIL result_hold: got q=%h r=%h done=%b want 6a 80 0", bus.quotient, bus.rem, bus.done);
    end
  endtask

  task automatic test_illegal_digit;
    int lat, s0; bit s0f, ok;
    drive_div(8'h40, 8'h80, 4'b0001, 4'b0011, 4'b1111, 4'b0000, 11'h000, 11'h000, 1'b0, lat, s0, s0f, ok);
    total++; if (lat !== 4) begin bad++; $display("FAIL illegal_latency: got %0d want 4", lat); end
    total++; if (bus.quotient !== 8'h80) begin bad++; $display("FAIL illegal_quot: got %h want 80", bus.quotient); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_hold_start;
    int lat, s0; bit s0f, ok;
    drive_div(8'h00, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 11'h2AA, 11'h556, 1'b1, lat, s0, s0f, ok);
    total++; if (lat !== 4) begin bad++; $display("FAIL zero_latency: got %0d want 4", lat); end
    total++; if (s0 !== 1) begin bad++; $display("FAIL zero_state0_cycles: got %0d want 1", s0); end
    total++; if (!ok) begin bad++; $display("FAIL zero_ops_held: got 0 want 1"); end
    total++; if (bus.quotient !== 8'h00) begin bad++; $display("FAIL zero_quot: got %h want 00", bus.quotient); end
    total++; if (bus.rem !== 8'h00) begin bad++; $display("FAIL zero_rem: got %h want 00", bus.rem); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat, s0; bit s0f, ok;
    drive_div(8'h40, 8'h80, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 11'h000, 11'h000, 1'b0, lat, s0, s0f, ok);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %b want 1", bus.done); end
    // Digits 0,-2 give -2, i.e. 0xFE in the low quotient bits.
    drive_div(8'h7F, 8'h80, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 11'h001, 11'h7FF, 1'b0, lat, s0, s0f, ok);
    total++; if (s0f !== 1'b1) begin bad++; $display("FAIL b2b_load_next: got %b want 1", s0f); end
    total++; if (lat !== 4) begin bad++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    total++; if (bus.quotient !== 8'hFE) begin bad++; $display("FAIL b2b_quot: got %h want fe", bus.quotient); end
    total++; if (bus.rem !== 8'h00) begin bad++; $display("FAIL b2b_rem: got %h want 00", bus.rem); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat, s0; bit s0f, ok;
    bus.a_in = 8'h50; bus.b_in = 8'hC0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    qj = 4'b0001;
    @(posedge clk); #1;
    reset_b = 1'b0;
    #1;
    total++;
    if ({op1, op2, state0, bus.busy, bus.done, bus.err} !== 20'h0) begin
      bad++; $display("FAIL midreset_ctrl: got %h want 0", {op1, op2, state0, bus.busy, bus.done, bus.err});
    end
    total++;
    if ({bus.quotient, bus.rem} !== 16'h0) begin
      bad++; $display("FAIL midreset_result: got %h want 0", {bus.quotient, bus.rem});
    end
    @(posedge clk); #1;
    reset_b = 1'b1;
    qj = '0;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL midreset_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    drive_div(8'h40, 8'h80, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 11'h155, 11'h6AB, 1'b0, lat, s0, s0f, ok);
    total++;
    if (lat !== 4 || bus.quotient !== 8'h80 || bus.rem !== 8'h00) begin
      bad++; $display("FAIL midreset_rerun: got lat=%0d q=%h r=%h want 4 80 00", lat, bus.quotient, bus.rem);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_opchk;
    int lat, s0; bit s0f, ok;
    drive_div(8'h10, 8'h40, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 11'h000, 11'h000, 1'b0, lat, s0, s0f, ok);
`ifdef DIVIDE16_OPCHK_EN
    total++; if (lat !== 0) begin bad++; $display("FAIL opchk_latency: got %0d want 0", lat); end
    total++; if (s0 !== 0) begin bad++; $display("FAIL opchk_state0: got %0d want 0", s0); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL opchk_err: got %b want 1", bus.err); end
    total++; if (bus.quotient !== 8'hFF || bus.rem !== 8'h00) begin
      bad++; $display("FAIL opchk_result: got q=%h r=%h want ff 00", bus.quotient, bus.rem);
    end
    drive_div(8'h40, 8'h80, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 11'h000, 11'h000, 1'b0, lat, s0, s0f, ok);
    total++; if (bus.err !== 1'b0 || bus.quotient !== 8'h80) begin
      bad++; $display("FAIL opchk_err_clear: got err=%b q=%h want 0 80", bus.err, bus.quotient);
    end
`else
    total++; if (lat !== 4) begin bad++; $display("FAIL opchk_latency: got %0d want 4", lat); end
    total++; if (s0 !== 1) begin bad++; $display("FAIL opchk_state0: got %0d want 1", s0); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL opchk_err: got %b want 0", bus.err); end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_correction();
    test_illegal_digit();
    test_zero_hold_start();
    test_back_to_back();
    test_reset_mid();
    test_opchk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/divide16_seq.md
Name: divide16_seq

Overview:
- Sequencing controller for the radix-16 SRT divider datapath, which retires two radix-4 digits per clock.
- Accepts a start/operand request, latches the operands and drives them into the datapath.
- Pulses the datapath load select, counts iterations and assembles the signed quotient digits into a binary quotient.
- Applies the final negative-remainder correction and presents the result with a done pulse.

Parameters:
- ITERS, 2, datapath cycles per division; quotient width QW = 4*ITERS.
- RW, 11, residual/sum/carry width of the datapath.

Ports:
- clk  input  1  clock
- reset_b  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a_in  input  8  dividend, fraction, must be < b_in
- b_in  input  8  divisor, fraction, normalised (bit7=1)
- op1  output  8  latched dividend to datapath
- op2  output  8  latched divisor to datapath
- state0  output  1  datapath load select (1 = load dividend, clear carry)
- qj  input  4  first digit, one-hot: [0]=+2, [1]=+1, [2]=-1, [3]=-2; all zero = 0
- qjn  input  4  second digit, same encoding
- sum2  input  RW  datapath residual sum after the second stage
- carry2  input  RW  datapath residual carry after the second stage
- busy  output  1  division in progress
- done  output  1  one-cycle result-valid pulse
- quotient  output  QW  floor(a*2^QW/b)
- rem  output  8  a*2^QW - quotient*b, range [0,b)
- err  output  1  operand violation (see Optional Feature)

Behaviour:
- Reset (async, reset_b=0) forces the following, mid-operation included, with no partial result kept:
  - state IDLE;
  - op1, op2, quotient, rem = 0;
  - state0, busy, done, err = 0;
  - counter and accumulator = 0.
- FSM states and actions:
  - IDLE: start=1 → latch a_in/b_in into op1/op2; go to LOAD.
  - LOAD, one cycle: state0=1, busy=1; clear accumulator, cnt=0 → ITER.
  - ITER: state0=0, busy=1.
    - Each cycle, decode v = 4*d(qj) + d(qjn), v in [-10,10]; ACC <= 16*ACC + v. ACC is signed, QW+2 bits.
    - cnt increments each cycle.
    - On cnt == ITERS-1, also capture R = sum2 + carry2 (RW-bit two's complement) → FIX.
  - FIX, one cycle, busy=1:
    - if R[RW-1]=1: ACC <= ACC-1 and R <= R + scaled divisor;
    - R is shifted down by the fixed datapath scaling to form rem → DONE.
  - DONE: done=1 for exactly one cycle, busy=0. start=1 here → behave as IDLE+start (back-to-back) → LOAD; else → IDLE.
- Latency: done is asserted in the cycle after edge N+ITERS+2, where edge N is the one that samples start.
- start while busy=1 is ignored, with no queueing.
- Illegal digit codes (more than one bit set) are treated as 0 and never corrupt the FSM.
- Result hold:
  - quotient/rem are updated only on the FIX→DONE edge and held until the next FIX completes.
  - op1/op2 are held constant from LOAD through FIX.
- Zero dividend: the digits are all 0, giving quotient=0 and rem=0 with normal latency.

Optional Feature:
- Macro DIVIDE16_OPCHK_EN.
- When defined:
  - in IDLE/DONE, start with b_in[7]=0 or a_in>=b_in skips LOAD/ITER and goes directly to DONE;
  - done=1, err=1, quotient=all ones, rem=0;
  - err clears at the next accepted start.
- When undefined:
  - err is tied 0;
  - no check is made; the result for illegal operands is undefined but the FSM sequence and latency are unchanged.

Test Plan:
- Reset mid-ITER (reset_b low for 1 cycle) → all outputs 0, state IDLE; the next start completes normally.
- a=0x40, b=0x80, ITERS=2 → state0 high exactly 1 cycle; done 4 cycles after start; quotient=0x80, rem=0x00.
- a=0x50, b=0xC0 → quotient=0x6A, rem=0x80. Bench forces a negative final residual via a digit sequence and checks that the correction path is exercised.
- a=0x00, b=0xFF → quotient=0x00, rem=0x00; start held high through the run is ignored while busy=1.
- Back-to-back: start in the DONE cycle with a=0x7F, b=0x80 → LOAD next cycle without passing through IDLE; quotient=0xFE, rem=0x00.
- Operand violation, DIVIDE16_OPCHK_EN defined: b=0x40 → done the cycle after start, err=1, quotient=0xFF, state0 never asserted. Undefined: err stays 0 and latency is 4.
